pipelined_add_sub: RTL and testbench
====================================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001: Parameter WIDTH, default 16: operand and result width in bits; SHALL be >= 2.
REQ-002: Parameter STAGES, default 4: number of register stages in the carry chain; SHALL be >= 1 and SHALL divide WIDTH exactly.
REQ-003: clk  input  1: single clock; all state updates on rising edge.
REQ-004: rst  input  1: reset, synchronous, active-high.
REQ-005: in_valid  input  1: operand beat present.
REQ-006: in_ready  output  1: block accepts operand beat this cycle.
REQ-007: a  input  WIDTH: operand A.
REQ-008: b  input  WIDTH: operand B.
REQ-009: cin  input  1: carry-in; used in add mode only.
REQ-010: sub  input  1: 0 = add, 1 = subtract.
REQ-011: out_valid  output  1: result beat present.
REQ-012: out_ready  input  1: downstream accepts result beat.
REQ-013: sum  output  WIDTH: result.
REQ-014: cout  output  1: carry-out of MSB; in sub mode, 1 = no borrow.
REQ-015: ovf  output  1: two's-complement signed overflow.

Function
REQ-016: Segment width SEG = WIDTH/STAGES; stage k SHALL compute bits [k*SEG +: SEG] as a ripple of full-adder cells, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-017: Add mode SHALL compute a + b + cin; sub mode SHALL compute a + ~b + 1, with cin ignored.
REQ-018: Operand bits for stages not yet processed, the partial sum, and the sub flag SHALL travel with the beat in per-stage registers, so each beat is independent of its neighbours.
REQ-019: Accepted beat = in_valid & in_ready on a rising edge; delivered beat = out_valid & out_ready.
REQ-020: Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stall occurs.
REQ-021: Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022: Stall: in_ready SHALL equal !out_valid | out_ready; while in_ready = 0, every stage register SHALL hold its contents.
REQ-023: Bubbles (in_valid = 0 while in_ready = 1) SHALL propagate as invalid slots; valid beats behind a bubble SHALL advance and not merge with it.
REQ-024: out_valid, sum, cout and ovf SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025: ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026: Beats SHALL leave the block in acceptance order; none SHALL be dropped or duplicated.
REQ-027: sum, cout and ovf are don't-care while out_valid = 0.
REQ-028: The STAGES = 1 configuration SHALL behave as a single registered full-width adder with the same handshake rules.

Reset
REQ-029: While rst = 1 at a clock edge, all per-stage valid bits SHALL clear; on the next cycle out_valid = 0, and sum, cout and ovf SHALL be 0.
REQ-030: in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-031: Reset mid-operation SHALL discard all in-flight beats; no pre-reset beat SHALL ever appear at the output.
REQ-032: A beat presented in a cycle where rst = 1 SHALL NOT be accepted.

Verification (WIDTH=8, STAGES=2)
REQ-033: add a=0xFF, b=0x01, cin=0, out_ready=1 -> 2 cycles later sum=0x00, cout=1, ovf=0.
REQ-034: sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1; sub a=0x01, b=0x02 -> sum=0xFF, cout=0, ovf=0.
REQ-035: add a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1, cout=0 (carry crosses the stage boundary at bit 4).
REQ-036: 6 back-to-back beats with out_ready=1 -> 6 consecutive out_valid cycles in order. Then drop out_ready for 3 cycles with 2 beats in flight -> in_ready=0, output held stable, no loss once out_ready rises.
REQ-037: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 afterwards, neither beat emerges, and in_ready=1 the following cycle.
REQ-038: Random-operand regression of 10k beats with random in_valid/out_ready -> every result matches the reference model (a±b, cout, ovf) in order.

Source files
------------

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_add_sub
// Purpose  : Carry-chain-pipelined two's-complement adder/subtractor with a
//            valid/ready handshake on both sides. The WIDTH-bit carry chain is
//            cut into STAGES equal segments. Each segment is a ripple of
//            full-adder cells that uses the carry registered by the segment
//            before it. Each beat carries its own operands, partial sum and
//            mode through the pipe, so neighbouring beats never interact.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - operand beat present
//            in_ready   - operand beat accepted this cycle
//            a, b       - operands (WIDTH bits)
//            cin        - carry-in (add mode only)
//            sub        - 0 = a + b + cin, 1 = a - b
//            out_valid  - result beat present
//            out_ready  - downstream accepts result beat
//            sum        - result (WIDTH bits)
//            cout       - carry-out of MSB (sub: 1 = no borrow)
//            ovf        - signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

  // Per-stage registers (_q) and their next-state values (_d).
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] sub_q, sub_d;
  logic [STAGES-1:0] c_q,   c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;

  // The whole pipe moves as one unit, so a single enable covers every stage.
  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = !out_valid | out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BASE = k * SEG;

    logic [WIDTH-1:0] w_a, w_b, w_s, w_sum;
    logic             w_c;
    logic [SEG:0]     w_cy;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1. B is inverted once here and then travels
      // already conditioned, and cin is replaced by the forced 1.
      assign w_a      = a;
      assign w_b      = sub ? ~b : b;
      assign w_s      = '0;
      assign w_c      = sub | cin;
      assign vld_d[k] = in_valid;
      assign sub_d[k] = sub;
    end else begin : g_next
      assign w_a      = a_q[k-1];
      assign w_b      = b_q[k-1];
      assign w_s      = s_q[k-1];
      assign w_c      = c_q[k-1];
      assign vld_d[k] = vld_q[k-1];
      assign sub_d[k] = sub_q[k-1];
    end

    assign w_cy[0] = w_c;

    // Bits inside this segment come from full-adder cells. Every other bit
    // passes the partial sum through unchanged.
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      if (j >= BASE && j < BASE + SEG) begin : g_fa
        assign w_sum[j]            = w_a[j] ^ w_b[j] ^ w_cy[j-BASE];
        assign w_cy[j-BASE+1]      = (w_a[j] & w_b[j]) | ((w_a[j] ^ w_b[j]) & w_cy[j-BASE]);
      end else begin : g_pass
        assign w_sum[j] = w_s[j];
      end
    end

    assign a_d[k] = w_a;
    assign b_d[k] = w_b;
    assign s_d[k] = w_sum;
    assign c_d[k] = w_cy[SEG];

    if (k == STAGES - 1) begin : g_last
      // The MSB is the top cell of the last segment. The carry into it is
      // w_cy[SEG-1], and the carry out of it is w_cy[SEG].
      assign ovf_d = w_cy[SEG] ^ w_cy[SEG-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sub_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (in_ready) begin
      vld_q <= vld_d;
      sub_q <= sub_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign sum  = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = ovf_q;

  // The last stage's operand copies and the travelling mode flag have no
  // reader once the final segment has been computed.
  logic w_unused;
  assign w_unused = ^{a_q[STAGES-1], b_q[STAGES-1], sub_q};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_add_sub
// Purpose  : Self-checking bench for pipelined_add_sub with WIDTH=8 and
//            STAGES=2. It runs directed corner cases, then a randomised
//            regression. Every delivered beat is compared with an arithmetic
//            reference model that is kept in an in-order queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  // Expected results in acceptance order, packed as {ovf, cout, sum}.
  logic [9:0] exp_q[$];

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference model built from plain signed and unsigned arithmetic.
  function automatic logic [9:0] ref_calc(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic rc, input logic rs);
    int       sa, sb, ci, r;
    logic [8:0] u;
    logic     co, ov;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    ci = rc ? 1 : 0;
    if (rs) begin
      u  = {1'b0, ra} - {1'b0, rb};
      co = (ra >= rb);
      r  = sa - sb;
    end else begin
      u  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      co = u[8];
      r  = sa + sb + ci;
    end
    ov = (r > 127) || (r < -128);
    return {ov, co, u[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle. The handshake is sampled mid-cycle, where the inputs are
  // settled and the outputs are stable. The task leaves the bench 1 ns after
  // the rising edge.
  task automatic tick();
    logic [9:0] e;
    #2;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_beat observed=1 expected=0");
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", {22'd0, ovf, cout, sum}, {22'd0, e});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_calc(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic dc, input logic ds);
    in_valid = v;
    a        = da;
    b        = db;
    cin      = dc;
    sub      = ds;
  endtask

  // Sends a single beat, then checks it two cycles later against constants.
  task automatic directed(input string tag, input logic [7:0] da, input logic [7:0] db,
                          input logic dc, input logic ds, input logic [9:0] expv);
    out_ready = 1'b1;
    drive(1'b1, da, db, dc, ds);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk(tag, {22'd0, ovf, cout, sum}, {22'd0, expv});
    tick();
  endtask

  initial begin
    int sent;
    int cyc;

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {22'd0, ovf, cout, sum}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Arithmetic corner cases, written as {ovf, cout, sum}.
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    directed("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFF});
    directed("add_7f_cin", 8'h7F, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80});
    directed("sub_cin_ign", 8'h05, 8'h05, 1'b1, 1'b1, {1'b0, 1'b1, 8'h00});

    // Six back-to-back beats: out_valid must be high for six consecutive cycles.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 6) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      else        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      chk("b2b_valid", {31'd0, out_valid}, {31'd0, (i >= 2 && i <= 7)});
    end
    tick();
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Two beats in flight, then out_ready is held low for three cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold", {22'd0, ovf, cout, sum}, {22'd0, exp_q[0]});
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("stall_no_loss", exp_q.size(), 32'd0);

    // Reset with two beats in flight. A beat presented during reset must not
    // be accepted.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    out_ready = 1'b0;
    rst       = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_result", {22'd0, ovf, cout, sum}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_emerge", {31'd0, out_valid}, 32'd0);
    end

    // Random regression with random valid and ready.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (in_valid && in_ready) sent++;
      #0;
      tick();
      cyc++;
    end
    chk("regress_sent", sent, 32'd10000);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("regress_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
